// File: rtl/ring_mon_pkg.sv
// ring_mon_pkg: shared state and fault-code definitions
// for the ring counter phase monitor.
package ring_mon_pkg;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [1:0] FC_NONE  = 2'd0;
   localparam logic [1:0] FC_DEAD  = 2'd1;
   localparam logic [1:0] FC_MULTI = 2'd2;
   localparam logic [1:0] FC_BREAK = 2'd3;

endpackage

// File: rtl/onehot_check.sv
// onehot_check: combinational zero / one-hot classifier.
// A vector that is neither is multi-hot.
module onehot_check #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] vec,
   output logic             is_zero,
   output logic             is_onehot
);

   logic [WIDTH-1:0] w_dec;

   assign w_dec     = vec - 1'b1;
   assign is_zero   = ~|vec;
   assign is_onehot = ~is_zero & ~|(vec & w_dec);

endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: locks onto a rotating one-hot ring,
// counts revolutions and reports sticky faults.
module ring_phase_monitor
   import ring_mon_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 2,
   parameter int REV_W    = 8,
   parameter int ERR_W    = 4
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] phase,
   input  logic             clr,
   output logic             locked,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [ERR_W-1:0] err_count,
   output logic [REV_W-1:0] rev_count
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] w_prev_nxt;
   logic [GW-1:0]    r_good;
   logic [GW-1:0]    w_good_nxt;
   logic [GW-1:0]    w_good_inc;
   logic             r_locked;
   logic             r_fault;
   logic [1:0]       r_code;
   logic [ERR_W-1:0] r_err;
   logic [REV_W-1:0] r_rev;

   logic             w_zero;
   logic             w_onehot;
   logic [WIDTH-1:0] w_exp;
   logic             w_match;
   logic             w_err;
   logic             w_rev;
   logic [1:0]       w_code;

   onehot_check #(
      .WIDTH (WIDTH)
   ) u_chk (
      .vec       (phase),
      .is_zero   (w_zero),
      .is_onehot (w_onehot)
   );

   assign w_exp      = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
   assign w_match    = w_onehot & (phase == w_exp);
   assign w_good_inc = r_good + 1'b1;
   assign w_code     = w_zero   ? FC_DEAD  :
                       w_onehot ? FC_BREAK : FC_MULTI;

   always_comb begin
      w_state_nxt = r_state;
      w_prev_nxt  = r_prev;
      w_good_nxt  = r_good;
      w_err       = 1'b0;
      w_rev       = 1'b0;
      if (en) begin
         unique case (r_state)
            SYNC: begin
               if (w_onehot) begin
                  w_prev_nxt  = phase;
                  w_good_nxt  = '0;
                  w_state_nxt = TRACK;
               end
            end
            TRACK: begin
               if (w_match) begin
                  w_prev_nxt = phase;
                  w_good_nxt = w_good_inc;
                  if (w_good_inc == LOCK_V)
                     w_state_nxt = LOCKED;
               end else if (w_onehot) begin
                  w_prev_nxt = phase;
                  w_good_nxt = '0;
               end else begin
                  w_state_nxt = SYNC;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  w_prev_nxt = phase;
                  // wrap from MSB back to bit0 closes one revolution
                  w_rev = r_prev[WIDTH-1] & phase[0];
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = SYNC;
               end
            end
            default: w_state_nxt = SYNC;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         r_state  <= SYNC;
         r_prev   <= '0;
         r_good   <= '0;
         r_locked <= 1'b0;
         r_fault  <= 1'b0;
         r_code   <= FC_NONE;
         r_err    <= '0;
         r_rev    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_prev   <= w_prev_nxt;
         r_good   <= w_good_nxt;
         r_locked <= (w_state_nxt == LOCKED);
         // a simultaneous error outranks clr
         if (w_err) begin
            r_fault <= 1'b1;
            r_err   <= clr     ? ERR_W'(1) :
                       &r_err  ? r_err     : r_err + 1'b1;
            if (clr || r_code == FC_NONE)
               r_code <= w_code;
         end else if (clr) begin
            r_fault <= 1'b0;
            r_err   <= '0;
            r_code  <= FC_NONE;
         end
         if (w_rev)
            r_rev <= clr ? REV_W'(1) : r_rev + 1'b1;
         else if (clr)
            r_rev <= '0;
      end
   end

   assign locked     = r_locked;
   assign fault      = r_fault;
   assign fault_code = r_code;
   assign err_count  = r_err;
   assign rev_count  = r_rev;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed plan steps plus random
// traffic, checked against a hot-index reference model.
module tb_ring_phase_monitor;

   localparam int W  = 4;
   localparam int LC = 2;

   logic       Clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] phase = 4'b0;
   logic       clr = 1'b0;
   logic       locked;
   logic       fault;
   logic [1:0] fault_code;
   logic [3:0] err_count;
   logic [7:0] rev_count;

   int errors = 0;
   int checks = 0;

   // model: mode 0=no reference, 1=tracking, 2=locked
   int m_mode = 0;
   int m_idx = 0;
   int m_good = 0;
   int m_fault = 0;
   int m_code = 0;
   int m_err = 0;
   int m_rev = 0;

   ring_phase_monitor #(
      .WIDTH    (4),
      .LOCK_CNT (2),
      .REV_W    (8),
      .ERR_W    (4)
   ) dut (
      .Clk        (Clk),
      .rst        (rst),
      .en         (en),
      .phase      (phase),
      .clr        (clr),
      .locked     (locked),
      .fault      (fault),
      .fault_code (fault_code),
      .err_count  (err_count),
      .rev_count  (rev_count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit e, input logic [3:0] p,
                        input bit c, input bit r);
      int n;
      int k;
      bit bad;
      bit rv;
      int code;
      n = $countones(p);
      k = 0;
      for (int i = 0; i < W; i++)
         if (p[i]) k = i;
      bad = 0;
      rv = 0;
      code = 0;
      if (r) begin
         m_mode = 0; m_idx = 0; m_good = 0;
         m_fault = 0; m_code = 0; m_err = 0; m_rev = 0;
         return;
      end
      if (e) begin
         if (m_mode == 0) begin
            if (n == 1) begin
               m_idx = k; m_good = 0; m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (n == 1 && k == (m_idx + 1) % W) begin
               m_idx = k; m_good++;
               if (m_good == LC) m_mode = 2;
            end else if (n == 1) begin
               m_idx = k; m_good = 0;
            end else begin
               m_mode = 0;
            end
         end else begin
            if (n == 1 && k == (m_idx + 1) % W) begin
               rv = (k == 0);
               m_idx = k;
            end else begin
               bad = 1;
               code = (n == 0) ? 1 : (n > 1) ? 2 : 3;
               m_mode = 0;
            end
         end
      end
      if (c) begin
         m_fault = 0; m_code = 0; m_err = 0; m_rev = 0;
      end
      if (bad) begin
         m_fault = 1;
         if (m_err < 15) m_err++;
         if (m_code == 0) m_code = code;
      end
      if (rv) m_rev = (m_rev + 1) % 256;
   endtask

   task automatic step(input bit e, input logic [3:0] p,
                       input bit c, input bit r);
      en = e; phase = p; clr = c; rst = r;
      @(posedge Clk);
      model(e, p, c, r);
      #1;
      chk("locked", int'(locked), int'(m_mode == 2));
      chk("fault", int'(fault), m_fault);
      chk("fault_code", int'(fault_code), m_code);
      chk("err_count", int'(err_count), m_err);
      chk("rev_count", int'(rev_count), m_rev);
   endtask

   task automatic seq(input logic [3:0] p);
      step(1, p, 0, 0);
   endtask

   initial begin
      logic [3:0] rp;
      int sel;
      step(0, 4'h0, 0, 1);
      step(1, 4'h5, 1, 1);
      chk("reset_locked", int'(locked), 0);
      chk("reset_err", int'(err_count), 0);

      seq(4'b0001); seq(4'b0010);
      chk("lock_early", int'(locked), 0);
      seq(4'b0100);
      chk("lock", int'(locked), 1);
      chk("lock_fault", int'(fault), 0);

      seq(4'b1000); seq(4'b0001); seq(4'b0010);
      chk("rev1", int'(rev_count), 1);
      chk("rev1_locked", int'(locked), 1);
      for (int i = 0; i < 2; i++) begin
         seq(4'b0100); seq(4'b1000); seq(4'b0001); seq(4'b0010);
      end
      chk("rev3", int'(rev_count), 3);

      seq(4'b0000);
      chk("dead_code", int'(fault_code), 1);
      chk("dead_err", int'(err_count), 1);
      chk("dead_locked", int'(locked), 0);
      seq(4'b0000); seq(4'b0000);
      chk("dead_noerr", int'(err_count), 1);

      step(0, 4'b0000, 1, 0);
      chk("clr_code", int'(fault_code), 0);
      seq(4'b1000); seq(4'b0001); seq(4'b0010);
      seq(4'b0010);
      chk("stall_code", int'(fault_code), 3);
      seq(4'b0100); seq(4'b1000); seq(4'b0001);
      seq(4'b0110);
      chk("multi_code", int'(fault_code), 3);
      chk("multi_err", int'(err_count), 2);
      for (int i = 0; i < 14; i++) begin
         seq(4'b0001); seq(4'b0010); seq(4'b0100); seq(4'b0000);
      end
      chk("err_sat", int'(err_count), 15);

      seq(4'b0001); seq(4'b0010); seq(4'b0100);
      for (int i = 0; i < 5; i++)
         step(0, 4'($urandom), 0, 0);
      chk("gate_locked", int'(locked), 1);
      step(1, 4'b0100, 1, 0);
      chk("clr_err_err", int'(err_count), 1);
      chk("clr_err_code", int'(fault_code), 3);
      chk("clr_err_rev", int'(rev_count), 0);

      seq(4'b0001); seq(4'b0010); seq(4'b0100); seq(4'b1000);
      seq(4'b0001); seq(4'b0010); seq(4'b0100); seq(4'b1000);
      seq(4'b0001);
      chk("pre_rst_rev", int'(rev_count), 2);
      step(1, 4'b0010, 0, 1);
      chk("rst_locked", int'(locked), 0);
      chk("rst_rev", int'(rev_count), 0);
      seq(4'b0001); seq(4'b0010);
      chk("relock_early", int'(locked), 0);
      seq(4'b0100);
      chk("relock", int'(locked), 1);

      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 75)      rp = 4'(1 << ((m_idx + 1) % W));
         else if (sel < 85) rp = 4'($urandom);
         else if (sel < 90) rp = 4'b0000;
         else               rp = 4'(1 << m_idx);
         step(($urandom % 8) != 0, rp,
              ($urandom % 40) == 0, ($urandom % 200) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Downstream checker for the 4-bit ring counter. It samples the counter's one-hot phase output and locks onto a valid rotation sequence. While locked it counts completed revolutions and flags dead rings (all-zero), multi-hot corruption and sequence breaks with sticky fault reporting. It sits directly on the ring counter's `Q` bus and feeds status logic or a test harness.

## Interface
Parameters:
- `WIDTH`, 4: phase bus width (ring length), ≥2
- `LOCK_CNT`, 2: consecutive correct rotations required to lock, ≥1
- `REV_W`, 8: revolution counter width
- `ERR_W`, 4: error counter width

Ports:
- `Clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  sample strobe; `phase` is evaluated only on edges with `en`=1
- `phase`  in  WIDTH  ring counter output (expected one-hot)
- `clr`  in  1  synchronous clear of `fault`, `fault_code`, `err_count`, `rev_count`
- `locked`  out  1  monitor is in LOCKED
- `fault`  out  1  sticky: an error was seen while LOCKED
- `fault_code`  out  2  first error since last clear: 0 none, 1 dead (all zero), 2 multi-hot, 3 sequence break
- `err_count`  out  ERR_W  errors seen while LOCKED, saturating
- `rev_count`  out  REV_W  completed revolutions, wraps modulo 2^REV_W

## Operation
- Expected next phase = rotate-left of previous: `{prev[WIDTH-2:0], prev[WIDTH-1]}` (bit0→bit1→…→MSB→bit0).
- Classification of a sample:
  - zero → dead
  - more than one bit set → multi-hot
  - one-hot but ≠ expected → break; this includes a repeated (held) value
- Internal regs: `prev[WIDTH-1:0]`, `good_cnt` (wide enough for `LOCK_CNT`), state.
- States:
  - **SYNC**, no reference:
    - one-hot sample → load `prev`, `good_cnt`=0, go TRACK
    - anything else → stay in SYNC
  - **TRACK**:
    - correct rotation → `prev`=phase, `good_cnt`++; when the new value equals `LOCK_CNT`, go LOCKED
    - wrong one-hot sample → reload `prev`, `good_cnt`=0, stay in TRACK
    - zero or multi-hot → go SYNC
    - No errors are counted in SYNC or TRACK.
  - **LOCKED**:
    - correct rotation → `prev`=phase; if `prev[WIDTH-1]`=1 and `phase[0]`=1, `rev_count`++
    - any error → `err_count`++ (saturate at all-ones), `fault`=1, `fault_code` set only if currently 0, go SYNC
- `en`=0: no state, `prev` or counter change. `clr` still acts.
- `clr` with a simultaneous LOCKED error: the error wins. Result is `err_count`=1, `fault`=1, `fault_code`=new code. `rev_count`=0.
- `clr` with a simultaneous revolution: `rev_count`=1.
- `clr` never changes state, `prev`, `good_cnt` or `locked`.

## Timing
- All outputs are registered. An `en` sample at edge N is reflected on outputs after edge N (visible in cycle N+1).
- Minimum lock latency: `LOCK_CNT`+1 enabled samples after entering SYNC.
- Reset (`rst`=1 at an edge): state SYNC, `prev`=0, `good_cnt`=0, `locked`=0, `fault`=0, `fault_code`=0, `err_count`=0, `rev_count`=0.
- `rst` overrides `en` and `clr`. Reset mid-lock drops `locked` at that edge.
- No combinational path from any input to any output.

## Structure
- Package `ring_mon_pkg`: state enum (`SYNC`, `TRACK`, `LOCKED`) and fault code constants (`FC_NONE`, `FC_DEAD`, `FC_MULTI`, `FC_BREAK`).
- Sub-module `onehot_check`: combinational, WIDTH-parameterised. Outputs `is_zero` and `is_onehot`; multi-hot = neither.
- Top: one FSM `always` block plus counter logic.

## Test plan
(`WIDTH`=4, `LOCK_CNT`=2, `en`=1 unless noted.)
- Lock: samples 0001, 0010, 0100 → `locked`=1 after the third edge. `fault`=0, counters 0.
- Revolution: from locked at 0100, feed 1000, 0001, 0010 → `rev_count`=1 and `locked` stays 1. Repeating two more full cycles → `rev_count`=3.
- Dead ring: locked, then 0000 → `fault`=1, `fault_code`=1, `err_count`=1, `locked`=0. Further 0000 samples leave `err_count`=1.
- Break and stall: locked at 0010, sample 0010 again → `fault_code`=3. Relock, then 0110 → `fault_code` stays 3, `err_count`=2. Reaching 16 errors → `err_count` saturates at 15.
- `en` gating and `clr`: locked, `en`=0 for 5 cycles with garbage on `phase` → no change. Then `clr`=1 together with a sequence break → `err_count`=1, `fault_code`=3, `rev_count`=0.
- Reset mid-operation: locked with `rev_count`=2, `rst`=1 for one edge → all outputs 0 next cycle. Relock takes 3 samples.
